// File: rtl/pulse_pkg.sv
// -----------------------------------------------------------------------------
// pulse_pkg
// Shared definitions for the pulse generation / measurement blocks.
//   - meas_state_e : pulse_meas FSM encoding (also exported on state_dbg)
//   - COUNT_WIDTH_DEFAULT : default counter width shared with pulse_gen
// -----------------------------------------------------------------------------
package pulse_pkg;

   localparam int unsigned COUNT_WIDTH_DEFAULT = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_MEAS = 2'd2
   } meas_state_e;

endpackage : pulse_pkg

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous level into the clk domain through a flop chain and
// reports single-cycle rise/fall strobes on the synchronized level.
//
// Ports:
//   clk     in   system clock (posedge)
//   reset   in   synchronous active-high reset, clears all flops
//   pulse_i in   asynchronous input level
//   s_o     out  synchronized level (last chain stage)
//   rise_o  out  s & ~s_d
//   fall_o  out  ~s & s_d
// -----------------------------------------------------------------------------
module sync_edge_detect #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic pulse_i,
   output logic s_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_d_q;

   // synchronizer chain plus one delay flop for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         s_d_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_i};
         s_d_q  <= sync_q[SYNC_STAGES-1];
      end
   end

   assign s_o    = sync_q[SYNC_STAGES-1];
   assign rise_o = sync_q[SYNC_STAGES-1] & ~s_d_q;
   assign fall_o = ~sync_q[SYNC_STAGES-1] & s_d_q;

endmodule : sync_edge_detect

// File: rtl/pulse_meas.sv
// -----------------------------------------------------------------------------
// pulse_meas
// Measures period (rise to rise) and high-time (rise to fall) of an external
// pulse train in clk cycles. One result per complete input cycle.
//
// Ports:
//   clk        in   system clock (posedge)
//   reset      in   synchronous active-high reset
//   run        in   enable; low holds the block in IDLE
//   pulse_in   in   asynchronous pulse input
//   period     out  last measured period
//   width      out  last measured high-time
//   valid      out  one-cycle strobe, period/width updated
//   meas_count out  number of valid strobes since reset (wraps)
//   overflow   out  sticky: counter saturated before a rise arrived
//   state_dbg  out  FSM state (0 IDLE, 1 ARM, 2 MEAS)
// -----------------------------------------------------------------------------
module pulse_meas
   import pulse_pkg::*;
#(
   parameter int unsigned COUNT_WIDTH = COUNT_WIDTH_DEFAULT,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   run,
   input  logic                   pulse_in,
   output logic [COUNT_WIDTH-1:0] period,
   output logic [COUNT_WIDTH-1:0] width,
   output logic                   valid,
   output logic [COUNT_WIDTH-1:0] meas_count,
   output logic                   overflow,
   output logic [1:0]             state_dbg
);

   localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = {COUNT_WIDTH{1'b1}};
   localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

   logic level_s;
   logic rise_s;
   logic fall_s;

   meas_state_e            state_q,      state_d;
   logic [COUNT_WIDTH-1:0] cnt_q,        cnt_d;
   logic [COUNT_WIDTH-1:0] hi_len_q,     hi_len_d;
   logic [COUNT_WIDTH-1:0] period_q,     period_d;
   logic [COUNT_WIDTH-1:0] width_q,      width_d;
   logic [COUNT_WIDTH-1:0] meas_count_q, meas_count_d;
   logic                   valid_q,      valid_d;
   logic                   overflow_q,   overflow_d;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .reset   (reset),
      .pulse_i (pulse_in),
      .s_o     (level_s),
      .rise_o  (rise_s),
      .fall_o  (fall_s)
   );

   // next-state and datapath decisions
   always_comb begin
      state_d      = state_q;
      hi_len_d     = hi_len_q;
      period_d     = period_q;
      width_d      = width_q;
      meas_count_d = meas_count_q;
      overflow_d   = overflow_q;
      valid_d      = 1'b0;
      // free-running saturating count; reloaded on rise, zeroed in IDLE
      cnt_d        = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

      if (!run) begin
         // dropping run discards any measurement in progress
         state_d    = ST_IDLE;
         cnt_d      = CNT_ZERO;
         overflow_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_d   = CNT_ZERO;
               state_d = ST_ARM;
            end
            ST_ARM: begin
               // first edge only establishes a reference, no result yet
               if (rise_s) begin
                  cnt_d    = CNT_ONE;
                  hi_len_d = CNT_ZERO;
                  state_d  = ST_MEAS;
               end else begin
                  state_d = ST_ARM;
               end
            end
            ST_MEAS: begin
               // a rise on the saturating cycle still counts as a result
               if (rise_s) begin
                  period_d     = cnt_q;
                  width_d      = hi_len_q;
                  valid_d      = 1'b1;
                  meas_count_d = meas_count_q + CNT_ONE;
                  cnt_d        = CNT_ONE;
               end else if (cnt_q == CNT_MAX) begin
                  overflow_d = 1'b1;
                  state_d    = ST_ARM;
               end else if (fall_s && !level_s) begin
                  hi_len_d = cnt_q;
               end else begin
                  state_d = ST_MEAS;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = CNT_ZERO;
            end
         endcase
      end
   end

   // state and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= CNT_ZERO;
         hi_len_q     <= CNT_ZERO;
         period_q     <= CNT_ZERO;
         width_q      <= CNT_ZERO;
         meas_count_q <= CNT_ZERO;
         valid_q      <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         hi_len_q     <= hi_len_d;
         period_q     <= period_d;
         width_q      <= width_d;
         meas_count_q <= meas_count_d;
         valid_q      <= valid_d;
         overflow_q   <= overflow_d;
      end
   end

   assign period     = period_q;
   assign width      = width_q;
   assign valid      = valid_q;
   assign meas_count = meas_count_q;
   assign overflow   = overflow_q;
   assign state_dbg  = state_q;

endmodule : pulse_meas

// File: tb/tb_pulse_meas.sv
// -----------------------------------------------------------------------------
// tb_pulse_meas
// Directed pulse trains with hand-computed results pushed into a queue; a
// monitor pops and compares on every valid strobe. DUT uses a 4-bit counter
// so saturation and meas_count wrap are reachable.
// -----------------------------------------------------------------------------
module tb_pulse_meas;

   localparam int CW = 4;

   typedef struct packed {
      logic [CW-1:0] p;
      logic [CW-1:0] w;
      logic [CW-1:0] c;
   } exp_t;

   logic          clk;
   logic          reset;
   logic          run;
   logic          pulse_in;
   logic [CW-1:0] period;
   logic [CW-1:0] width;
   logic          valid;
   logic [CW-1:0] meas_count;
   logic          overflow;
   logic [1:0]    state_dbg;

   exp_t          exp_q[$];
   logic [CW-1:0] exp_cnt;
   int            checks;
   int            errors;

   pulse_meas #(
      .COUNT_WIDTH (CW),
      .SYNC_STAGES (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .pulse_in   (pulse_in),
      .period     (period),
      .width      (width),
      .valid      (valid),
      .meas_count (meas_count),
      .overflow   (overflow),
      .state_dbg  (state_dbg)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int p, input int w);
      exp_t e;
      exp_cnt = exp_cnt + 4'd1;
      e.p = p[CW-1:0];
      e.w = w[CW-1:0];
      e.c = exp_cnt;
      exp_q.push_back(e);
   endtask

   task automatic drive_pulse(input int p, input int w);
      pulse_in = 1'b1;
      cyc(w);
      pulse_in = 1'b0;
      cyc(p - w);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_period"}, 32'(period), 32'd0);
      chk({tag, "_width"}, 32'(width), 32'd0);
      chk({tag, "_valid"}, 32'(valid), 32'd0);
      chk({tag, "_count"}, 32'(meas_count), 32'd0);
      chk({tag, "_ovf"}, 32'(overflow), 32'd0);
      chk({tag, "_state"}, 32'(state_dbg), 32'd0);
   endtask

   // scoreboard monitor: every valid must match the oldest expectation
   always @(negedge clk) begin
      if (valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL unexpected_valid: period %0d width %0d count %0d at %0t",
                     period, width, meas_count, $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_period", 32'(period), 32'(e.p));
            chk("sb_width", 32'(width), 32'(e.w));
            chk("sb_count", 32'(meas_count), 32'(e.c));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n_meas;
      int n_ovf;
      checks   = 0;
      errors   = 0;
      exp_cnt  = '0;
      reset    = 1'b1;
      run      = 1'b0;
      pulse_in = 1'b0;
      cyc(3);
      chk_zero_outputs("reset");
      reset = 1'b0;
      cyc(2);
      chk("idle_state", 32'(state_dbg), 32'd0);

      // 10/3 train: first valid only after second rise
      run = 1'b1;
      cyc(2);
      chk("arm_state", 32'(state_dbg), 32'd1);
      for (int i = 0; i < 4; i++) push(10, 3);
      for (int i = 0; i < 5; i++) drive_pulse(10, 3);

      // minimum waveform 2/1, chained to previous train
      push(10, 3);
      for (int i = 0; i < 5; i++) push(2, 1);
      for (int i = 0; i < 6; i++) drive_pulse(2, 1);

      // single-cycle low gap between long highs
      push(2, 1);
      push(6, 5);
      push(6, 5);
      for (int i = 0; i < 3; i++) drive_pulse(6, 5);
      cyc(3);
      chk("drain_a", 32'(exp_q.size()), 32'd0);
      run = 1'b0;
      cyc(2);
      chk("runoff_state", 32'(state_dbg), 32'd0);

      // overflow: one rise then constant low; edge launched mid-cycle
      run = 1'b1;
      cyc(2);
      @(posedge clk);
      #2 pulse_in = 1'b1;
      n_meas = 0;
      n_ovf  = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #2;
         if (n == 2) pulse_in = 1'b0;
         if (state_dbg == 2'd2 && n_meas == 0) n_meas = n;
         if (overflow === 1'b1 && n_ovf == 0) n_ovf = n;
      end
      @(negedge clk);
      chk("rise_latency", 32'(n_meas), 32'd3);
      chk("ovf_latency", 32'(n_ovf), 32'd18);
      chk("ovf_rearm_state", 32'(state_dbg), 32'd1);
      chk("ovf_flag", 32'(overflow), 32'd1);

      // 6/2 train after overflow, flag stays sticky
      for (int i = 0; i < 3; i++) push(6, 2);
      for (int i = 0; i < 4; i++) drive_pulse(6, 2);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      chk("drain_b", 32'(exp_q.size()), 32'd0);

      // drop run mid-high, restore 5 cycles later
      pulse_in = 1'b1;
      cyc(1);
      run = 1'b0;
      cyc(5);
      chk("drop_state", 32'(state_dbg), 32'd0);
      chk("drop_ovf", 32'(overflow), 32'd0);
      run = 1'b1;
      cyc(2);
      pulse_in = 1'b0;
      cyc(3);
      push(7, 3);
      push(7, 3);
      for (int i = 0; i < 3; i++) drive_pulse(7, 3);

      // period equal to counter max: rise wins, no overflow
      push(7, 3);
      push(15, 4);
      push(3, 1);
      drive_pulse(15, 4);
      drive_pulse(3, 1);
      drive_pulse(3, 1);
      cyc(2);
      chk("sat_no_ovf", 32'(overflow), 32'd0);
      chk("drain_c", 32'(exp_q.size()), 32'd0);

      // reset in the middle of a measurement
      push(5, 1);
      pulse_in = 1'b1;
      cyc(5);
      pulse_in = 1'b0;
      cyc(1);
      chk("drain_d", 32'(exp_q.size()), 32'd0);
      reset = 1'b1;
      cyc(1);
      chk_zero_outputs("midreset");
      reset   = 1'b0;
      exp_cnt = '0;
      push(5, 2);
      push(5, 2);
      for (int i = 0; i < 3; i++) drive_pulse(5, 2);
      cyc(2);
      chk("drain_e", 32'(exp_q.size()), 32'd0);
      chk("final_count", 32'(meas_count), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_pulse_meas
